// File: rtl/snespad_pkg.sv
// State encoding and ns-to-clock timing helpers shared by the SNES pad poller.
// Pure declarations: no logic, no latency.
package snespad_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_LOW,
      S_HIGH,
      S_DONE
   } state_t;

   // Latch phase length in units of dclock half-periods.
   localparam int LATCH_TICKS = 2;

   function automatic int ns_to_clks(input int ns, input int clk_per_ns);
      return ns / clk_per_ns;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snespad_shift_lane.sv
// One pad's capture register: clears on latch, stores the inverted data line at bit_idx_i on each strobe.
// Result is visible the cycle after the strobe; no backpressure.
module snespad_shift_lane
   import snespad_pkg::*;
#(
   parameter int REG_SIZE = 16,
   parameter int BIT_W    = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                sample_i,
   input  logic [BIT_W-1:0]    bit_idx_i,
   input  logic                sdata_i,
   output logic [REG_SIZE-1:0] word_o
);

   logic [REG_SIZE-1:0] word_q, word_d;

   always_comb begin
      word_d = word_q;
      if (clear_i) begin
         word_d = '0;
      end else if (sample_i) begin
         word_d[bit_idx_i] = ~sdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign word_o = word_q;

endmodule

// File: rtl/snespad_poll_ctrl.sv
// Shares one SNES latch/clock bus across NPADS pads; a frame takes 2+2*REG_SIZE-1 ticks plus 2 cycles.
// Frames are offered valid/ready; an unaccepted frame is overwritten and overrun_o latches.
module snespad_poll_ctrl
   import snespad_pkg::*;
#(
   parameter int CLK_PER_NS = 40,
   parameter int NPADS      = 2,
   parameter int REG_SIZE   = 16,
   parameter int HALF_NS    = 6000,
   parameter int POLL_NS    = 16_666_667
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      enable_i,
   input  logic                      req_i,
   output logic                      dlatch_o,
   output logic                      dclock_o,
   input  logic [NPADS-1:0]          sdata_i,
   output logic [NPADS*REG_SIZE-1:0] pad_data_o,
   output logic                      frame_valid_o,
   input  logic                      frame_ready_i,
   output logic [NPADS-1:0]          changed_o,
   output logic                      overrun_o,
   output logic                      busy_o
);

   localparam int HALF_CLKS = ns_to_clks(HALF_NS, CLK_PER_NS);
   localparam int POLL_CLKS = ns_to_clks(POLL_NS, CLK_PER_NS);
   localparam int TICK_W    = cnt_width(LATCH_TICKS * HALF_CLKS);
   localparam int POLL_W    = cnt_width(POLL_CLKS);
   localparam int BIT_W     = cnt_width(REG_SIZE);

   localparam logic [TICK_W-1:0] HALF_LAST  = TICK_W'(HALF_CLKS - 1);
   localparam logic [TICK_W-1:0] LATCH_LAST = TICK_W'(LATCH_TICKS * HALF_CLKS - 1);
   localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CLKS - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(REG_SIZE - 1);

   state_t                    state_q, state_d;
   logic [TICK_W-1:0]         tick_q, tick_d;
   logic [BIT_W-1:0]          bit_q, bit_d;
   logic [POLL_W-1:0]         poll_q, poll_d;
   logic                      pending_q, pending_d;
   logic [NPADS*REG_SIZE-1:0] pad_data_q, pad_data_d;
   logic                      valid_q, valid_d;
   logic [NPADS-1:0]          changed_q, changed_d;
   logic                      overrun_q, overrun_d;

   logic                      lane_clear, lane_sample, poll_trig, start;
   logic [NPADS*REG_SIZE-1:0] lane_words;

   for (genvar k = 0; k < NPADS; k++) begin : g_lane
      snespad_shift_lane #(
         .REG_SIZE (REG_SIZE),
         .BIT_W    (BIT_W)
      ) u_lane (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .clear_i   (lane_clear),
         .sample_i  (lane_sample),
         .bit_idx_i (bit_q),
         .sdata_i   (sdata_i[k]),
         .word_o    (lane_words[k*REG_SIZE +: REG_SIZE])
      );
   end

   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q + 1'b1;
      bit_d       = bit_q;
      lane_clear  = 1'b0;
      lane_sample = 1'b0;
      case (state_q)
         S_IDLE: begin
            tick_d = '0;
            if (pending_q) state_d = S_LATCH;
         end
         S_LATCH: begin
            lane_clear = 1'b1;
            bit_d      = '0;
            if (tick_q == LATCH_LAST) state_d = S_LOW;
         end
         S_LOW: begin
            // Sample late in the low phase so the pad's output has settled.
            if (tick_q == HALF_LAST) begin
               lane_sample = 1'b1;
               state_d     = (bit_q == BIT_LAST) ? S_DONE : S_HIGH;
            end
         end
         S_HIGH: begin
            if (tick_q == HALF_LAST) begin
               bit_d   = bit_q + 1'b1;
               state_d = S_LOW;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) tick_d = '0;
   end

   // Triggers arriving mid-frame collapse into a single pending frame.
   always_comb begin
      poll_trig = enable_i && (poll_q == POLL_LAST);
      poll_d    = (!enable_i || poll_trig) ? '0 : poll_q + 1'b1;
      start     = (state_q == S_IDLE) && pending_q;
      pending_d = (pending_q && !start) || req_i || poll_trig;
   end

   always_comb begin
      pad_data_d = pad_data_q;
      valid_d    = valid_q;
      changed_d  = changed_q;
      overrun_d  = overrun_q;
      if (state_q == S_DONE) begin
         pad_data_d = lane_words;
         valid_d    = 1'b1;
         for (int k = 0; k < NPADS; k++) begin
            changed_d[k] = lane_words[k*REG_SIZE +: REG_SIZE] != pad_data_q[k*REG_SIZE +: REG_SIZE];
         end
         // A same-cycle accept consumes the old frame, so only an unaccepted one is lost.
         if (valid_q && !frame_ready_i) overrun_d = 1'b1;
      end else if (valid_q && frame_ready_i) begin
         valid_d   = 1'b0;
         changed_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         poll_q     <= '0;
         pending_q  <= 1'b0;
         pad_data_q <= '0;
         valid_q    <= 1'b0;
         changed_q  <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         poll_q     <= poll_d;
         pending_q  <= pending_d;
         pad_data_q <= pad_data_d;
         valid_q    <= valid_d;
         changed_q  <= changed_d;
         overrun_q  <= overrun_d;
      end
   end

   assign dlatch_o      = (state_q == S_LATCH);
   assign dclock_o      = (state_q == S_HIGH);
   assign busy_o        = (state_q != S_IDLE);
   assign pad_data_o    = pad_data_q;
   assign frame_valid_o = valid_q;
   assign changed_o     = changed_q;
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_snespad_poll_ctrl.sv
// Scoreboard bench for snespad_poll_ctrl: pad models answer the shared bus, expected frames are queued
// at stimulus time and a monitor pops one on every completed frame.
module tb_snespad_poll_ctrl;

   localparam int NPADS      = 2;
   localparam int REG_SIZE   = 16;
   localparam int HALF       = 400 / 40;
   localparam int POLL       = 20000 / 40;
   localparam int FRAME_BUSY = 2 * HALF + (2 * REG_SIZE - 1) * HALF + 1;

   typedef struct {
      logic [NPADS*REG_SIZE-1:0] data;
      logic [NPADS-1:0]          chg;
   } exp_t;

   logic                      clk_i = 1'b0;
   logic                      rst_i = 1'b1;
   logic                      enable_i = 1'b0;
   logic                      req_i = 1'b0;
   logic                      frame_ready_i = 1'b0;
   logic                      dlatch_o, dclock_o, frame_valid_o, overrun_o, busy_o;
   logic [NPADS-1:0]          sdata_i;
   logic [NPADS*REG_SIZE-1:0] pad_data_o;
   logic [NPADS-1:0]          changed_o;

   logic [NPADS-1:0][REG_SIZE-1:0] words = '0;
   logic [3:0]                     pad_idx = '0;
   logic                           dclk_prev = 1'b0;

   exp_t                      exp_q[$];
   logic [NPADS*REG_SIZE-1:0] last_pub = '0;
   logic                      valid_m = 1'b0;
   logic                      overrun_m = 1'b0;
   int                        tests = 0;
   int                        fails = 0;
   int                        pubs = 0;
   logic                      busy_prev = 1'b0;
   logic                      rst_last = 1'b1;

   snespad_poll_ctrl #(
      .CLK_PER_NS (40),
      .NPADS      (NPADS),
      .REG_SIZE   (REG_SIZE),
      .HALF_NS    (400),
      .POLL_NS    (20000)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .enable_i      (enable_i),
      .req_i         (req_i),
      .dlatch_o      (dlatch_o),
      .dclock_o      (dclock_o),
      .sdata_i       (sdata_i),
      .pad_data_o    (pad_data_o),
      .frame_valid_o (frame_valid_o),
      .frame_ready_i (frame_ready_i),
      .changed_o     (changed_o),
      .overrun_o     (overrun_o),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Pad model: latch reloads bit 0, each rising dclock advances one bit, data line is active-low.
   always @(posedge clk_i) begin
      if (dlatch_o) pad_idx <= '0;
      else if (dclock_o && !dclk_prev) pad_idx <= pad_idx + 4'd1;
      dclk_prev <= dclock_o;
      rst_last = rst_i;
   end

   always_comb begin
      sdata_i = '1;
      for (int k = 0; k < NPADS; k++) sdata_i[k] = ~words[k][pad_idx];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_expect();
      exp_t e;
      e.data = words;
      for (int k = 0; k < NPADS; k++) e.chg[k] = (words[k] != last_pub[k*REG_SIZE +: REG_SIZE]);
      last_pub = words;
      exp_q.push_back(e);
   endtask

   task automatic model_publish(input bit rdy);
      if (valid_m && !rdy) overrun_m = 1'b1;
      valid_m = 1'b1;
   endtask

   task automatic randomize_words();
      for (int k = 0; k < NPADS; k++) words[k] = 16'($urandom);
   endtask

   task automatic do_frame(input bit rdy_done);
      push_expect();
      @(negedge clk_i); req_i = 1'b1;
      @(negedge clk_i); req_i = 1'b0;
      repeat (FRAME_BUSY) @(negedge clk_i);
      frame_ready_i = rdy_done;
      @(negedge clk_i);
      frame_ready_i = 1'b0;
      chk("frame_end_idle", 32'(busy_o), 32'd0);
      model_publish(rdy_done);
      chk("valid_after_pub", 32'(frame_valid_o), 32'(valid_m));
      chk("overrun_after_pub", 32'(overrun_o), 32'(overrun_m));
   endtask

   task automatic accept();
      @(negedge clk_i); frame_ready_i = 1'b1;
      @(negedge clk_i); frame_ready_i = 1'b0;
      valid_m = 1'b0;
      chk("valid_after_accept", 32'(frame_valid_o), 32'(valid_m));
      chk("changed_after_accept", 32'(changed_o), 32'd0);
      chk("data_held", pad_data_o, last_pub);
   endtask

   always @(negedge clk_i) begin
      if (busy_prev && !busy_o && !rst_last) begin
         pubs++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_publish: data %0h with nothing expected", pad_data_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pub_data", pad_data_o, e.data);
            chk("pub_changed", 32'(changed_o), 32'(e.chg));
            chk("pub_valid", 32'(frame_valid_o), 32'd1);
         end
      end
      busy_prev = busy_o;
   end

   initial begin
      #2_000_000;
      fails++;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, busy_n, rises, bad_lo, bad_hi, run, first_busy, base, nrise;
      logic prev_c, prevb, ended;
      int starts[3];

      repeat (3) @(negedge clk_i);
      chk("rst_dlatch", 32'(dlatch_o), 32'd0);
      chk("rst_dclock", 32'(dclock_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_valid", 32'(frame_valid_o), 32'd0);
      chk("rst_data", pad_data_o, 32'd0);
      chk("rst_changed", 32'(changed_o), 32'd0);
      chk("rst_overrun", 32'(overrun_o), 32'd0);
      rst_i = 1'b0;

      // Timing and decode: pad 0 presses A5C3, pad 1 presses nothing.
      words[0] = 16'hA5C3;
      words[1] = 16'h0000;
      push_expect();
      @(negedge clk_i); req_i = 1'b1;
      @(negedge clk_i); req_i = 1'b0;
      lat = 0; busy_n = 0; rises = 0; bad_lo = 0; bad_hi = 0; run = 0;
      first_busy = -1; prev_c = 1'b0; ended = 1'b0;
      for (int c = 1; c <= 1000; c++) begin
         if (busy_o) begin
            busy_n++;
            if (first_busy < 0) first_busy = c;
         end
         if (dlatch_o) lat++;
         if (busy_o && !dlatch_o) begin
            if (dclock_o != prev_c) begin
               if (!prev_c) begin
                  rises++;
                  if (run != HALF) bad_lo++;
               end else if (run != HALF) begin
                  bad_hi++;
               end
               run = 1;
            end else begin
               run++;
            end
         end
         prev_c = dclock_o;
         if (first_busy >= 0 && !busy_o) begin
            ended = 1'b1;
            break;
         end
         @(negedge clk_i);
      end
      chk("frame_completed", 32'(ended), 32'd1);
      chk("req_to_busy", 32'(first_busy), 32'd2);
      chk("latch_cycles", 32'(lat), 32'(2 * HALF));
      chk("clock_rises", 32'(rises), 32'(REG_SIZE - 1));
      chk("bad_low_phases", 32'(bad_lo), 32'd0);
      chk("bad_high_phases", 32'(bad_hi), 32'd0);
      chk("last_low_plus_done", 32'(run), 32'(HALF + 1));
      chk("busy_cycles", 32'(busy_n), 32'(FRAME_BUSY));
      model_publish(1'b0);
      chk("decode_valid", 32'(frame_valid_o), 32'(valid_m));
      accept();

      // Handshake: unaccepted frame, then publish with same-cycle accept, then a true overrun.
      randomize_words(); do_frame(1'b0);
      randomize_words(); do_frame(1'b1);
      randomize_words(); do_frame(1'b0);
      randomize_words(); do_frame(1'b0);
      accept();
      chk("overrun_sticky", 32'(overrun_o), 32'(overrun_m));

      // Three requests during one frame yield exactly one extra frame.
      frame_ready_i = 1'b1;
      randomize_words();
      push_expect();
      push_expect();
      base = pubs;
      @(negedge clk_i); req_i = 1'b1;
      @(negedge clk_i); req_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         repeat (50) @(negedge clk_i);
         req_i = 1'b1;
         @(negedge clk_i);
         req_i = 1'b0;
      end
      for (int c = 0; c < 1500 && pubs < base + 2; c++) @(negedge clk_i);
      chk("collapse_two_frames", 32'(pubs - base), 32'd2);
      repeat (400) @(negedge clk_i);
      chk("collapse_no_third", 32'(pubs - base), 32'd2);
      chk("collapse_idle", 32'(busy_o), 32'd0);
      frame_ready_i = 1'b0;
      valid_m = 1'b0;
      chk("collapse_valid_drained", 32'(frame_valid_o), 32'(valid_m));

      // Periodic polling with the consumer always ready.
      frame_ready_i = 1'b1;
      randomize_words();
      repeat (3) push_expect();
      base = pubs;
      nrise = 0;
      starts = '{0, 0, 0};
      prevb = busy_o;
      @(negedge clk_i); enable_i = 1'b1;
      for (int c = 0; c < 2000 && nrise < 3; c++) begin
         @(negedge clk_i);
         if (busy_o && !prevb) begin
            starts[nrise] = c;
            nrise++;
         end
         prevb = busy_o;
      end
      enable_i = 1'b0;
      chk("poll_starts", 32'(nrise), 32'd3);
      chk("poll_interval_1", 32'(starts[1] - starts[0]), 32'(POLL));
      chk("poll_interval_2", 32'(starts[2] - starts[1]), 32'(POLL));
      for (int c = 0; c < 1000 && pubs < base + 3; c++) @(negedge clk_i);
      chk("poll_frames", 32'(pubs - base), 32'd3);
      nrise = 0;
      prevb = busy_o;
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk_i);
         if (busy_o && !prevb) nrise++;
         prevb = busy_o;
      end
      chk("poll_stopped", 32'(nrise), 32'd0);
      frame_ready_i = 1'b0;
      valid_m = 1'b0;
      chk("poll_valid_drained", 32'(frame_valid_o), 32'(valid_m));
      chk("poll_overrun", 32'(overrun_o), 32'(overrun_m));

      // Reset during the high phase of bit 7 aborts the frame with nothing published.
      randomize_words();
      @(negedge clk_i); req_i = 1'b1;
      @(negedge clk_i); req_i = 1'b0;
      repeat (2 * HALF + 7 * 2 * HALF + HALF + 3) @(negedge clk_i);
      chk("in_high_bit7", 32'(dclock_o), 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      last_pub = '0;
      valid_m = 1'b0;
      overrun_m = 1'b0;
      chk("abort_dlatch", 32'(dlatch_o), 32'd0);
      chk("abort_dclock", 32'(dclock_o), 32'd0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_valid", 32'(frame_valid_o), 32'(valid_m));
      chk("abort_data", pad_data_o, last_pub);
      chk("abort_overrun", 32'(overrun_o), 32'(overrun_m));
      rst_i = 1'b0;
      repeat (5) @(negedge clk_i);
      chk("abort_no_restart", 32'(busy_o), 32'd0);

      randomize_words(); do_frame(1'b0);
      repeat (5) @(negedge clk_i);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
